// File: rtl/fft_in_framer.sv
`default_nettype none
// fft_in_framer: packs a valid/ready sample stream into frames held in a two-bank
// ping-pong buffer and bursts each frame out as FRAME_WORDS words of NUM_IN_OUT lanes.
module fft_in_framer #(
  parameter int DATA_WIDTH  = 9,
  parameter int NUM_IN_OUT  = 16,
  parameter int FRAME_WORDS = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_i,
  input  logic signed [DATA_WIDTH-1:0] s_q,
  input  logic                         flush,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] dout_i [0:NUM_IN_OUT-1],
  output logic signed [DATA_WIDTH-1:0] dout_q [0:NUM_IN_OUT-1],
  output logic                         dout_valid,
  output logic                         frame_start,
  output logic                         frame_end
);
  localparam int LW = (NUM_IN_OUT > 1) ? $clog2(NUM_IN_OUT) : 1;
  localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_IN_OUT - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(FRAME_WORDS - 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  logic signed [DATA_WIDTH-1:0] mem_i [0:1][0:FRAME_WORDS-1][0:NUM_IN_OUT-1];
  logic signed [DATA_WIDTH-1:0] mem_q [0:1][0:FRAME_WORDS-1][0:NUM_IN_OUT-1];

  state_t        state;
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [LW-1:0] wr_lane;
  logic [WW-1:0] wr_word;
  logic [WW-1:0] rd_word;

  logic          accept;
  logic          fill_done;
  logic          rd_done;
  logic          wr_bank_nx;
  logic [1:0]    full_nx;

  // A fill and a drain always touch different banks, so both updates can apply.
  always_comb begin
    accept     = s_valid && s_ready && !flush;
    fill_done  = accept && (wr_lane == LAST_LANE) && (wr_word == LAST_WORD);
    rd_done    = (state == BURST) && (rd_word == LAST_WORD);
    wr_bank_nx = fill_done ? ~wr_bank : wr_bank;
    full_nx    = full;
    if (rd_done) full_nx[rd_bank] = 1'b0;
    if (fill_done) full_nx[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_i[wr_bank][wr_word][wr_lane] <= s_i;
      mem_q[wr_bank][wr_word][wr_lane] <= s_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_ready <= 1'b0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
      wr_lane <= '0;
      wr_word <= '0;
    end else begin
      s_ready <= !full_nx[wr_bank_nx];
      full    <= full_nx;
      wr_bank <= wr_bank_nx;
      if (flush) begin
        wr_lane <= '0;
        wr_word <= '0;
      end else if (accept) begin
        if (wr_lane == LAST_LANE) begin
          wr_lane <= '0;
          wr_word <= (wr_word == LAST_WORD) ? '0 : wr_word + 1'b1;
        end else begin
          wr_lane <= wr_lane + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      rd_bank     <= 1'b0;
      rd_word     <= '0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      for (int l = 0; l < NUM_IN_OUT; l++) begin
        dout_i[l] <= '0;
        dout_q[l] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          dout_valid  <= 1'b0;
          frame_start <= 1'b0;
          frame_end   <= 1'b0;
          rd_word     <= '0;
          for (int l = 0; l < NUM_IN_OUT; l++) begin
            dout_i[l] <= '0;
            dout_q[l] <= '0;
          end
          if (full[rd_bank] && out_ready) state <= BURST;
        end
        BURST: begin
          dout_valid  <= 1'b1;
          frame_start <= (rd_word == '0);
          frame_end   <= (rd_word == LAST_WORD);
          for (int l = 0; l < NUM_IN_OUT; l++) begin
            dout_i[l] <= mem_i[rd_bank][rd_word][l];
            dout_q[l] <= mem_q[rd_bank][rd_word][l];
          end
          if (rd_done) begin
            rd_word <= '0;
            rd_bank <= ~rd_bank;
            // Chain straight into the other bank when it is already waiting.
            state   <= (full[~rd_bank] && out_ready) ? BURST : IDLE;
          end else begin
            rd_word <= rd_word + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
